// File: rtl/uart_tx_fsm.sv
// UART transmitter: start bit, DBIT data bits LSB-first, optional even parity, stop period.
// Bit timing comes from an internal divider producing 16 oversample ticks per bit.
module uart_tx_fsm #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int CLK_DIV = 163,
    parameter int PAR_EN  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done_tick
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int SW = $clog2((SB_TICK > 16) ? SB_TICK : 16);

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [SW-1:0] BIT_LAST  = SW'(15);
    localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [2:0]    N_LAST    = 3'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state_r;
    logic [DW-1:0]     div_r;
    logic [SW-1:0]     s_cnt_r;
    logic [2:0]        n_cnt_r;
    logic [DBIT-1:0]   b_reg_r;
    logic              p_reg_r;
    logic              tx_reg_r;
    logic              busy_r;
    logic              s_tick_s;

    assign s_tick_s     = (div_r == DIV_LAST);
    assign tx_done_tick = (state_r == STOP) && s_tick_s && (s_cnt_r == STOP_LAST);
    assign tx           = tx_reg_r;
    assign tx_busy      = busy_r;

    // Frame sequencer: divider, counters, shift/parity registers and registered line/busy outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            div_r    <= '0;
            s_cnt_r  <= '0;
            n_cnt_r  <= 3'd0;
            b_reg_r  <= '0;
            p_reg_r  <= 1'b0;
            tx_reg_r <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            // Divider idles at zero so a frame always starts on a fresh tick phase.
            if ((state_r == IDLE) || s_tick_s) begin
                div_r <= '0;
            end else begin
                div_r <= div_r + 1'b1;
            end

            case (state_r)
                IDLE: begin
                    tx_reg_r <= 1'b1;
                    if (tx_start) begin
                        b_reg_r  <= din[DBIT-1:0];
                        s_cnt_r  <= '0;
                        n_cnt_r  <= 3'd0;
                        p_reg_r  <= 1'b0;
                        tx_reg_r <= 1'b0;
                        busy_r   <= 1'b1;
                        state_r  <= START;
                    end
                end
                START: begin
                    if (s_tick_s) begin
                        if (s_cnt_r == BIT_LAST) begin
                            s_cnt_r  <= '0;
                            tx_reg_r <= b_reg_r[0];
                            state_r  <= DATA;
                        end else begin
                            s_cnt_r <= s_cnt_r + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick_s) begin
                        if (s_cnt_r == BIT_LAST) begin
                            s_cnt_r <= '0;
                            p_reg_r <= p_reg_r ^ b_reg_r[0];
                            b_reg_r <= b_reg_r >> 1;
                            if (n_cnt_r == N_LAST) begin
                                if (PAR_EN != 0) begin
                                    tx_reg_r <= p_reg_r ^ b_reg_r[0];
                                    state_r  <= PARITY;
                                end else begin
                                    tx_reg_r <= 1'b1;
                                    state_r  <= STOP;
                                end
                            end else begin
                                n_cnt_r  <= n_cnt_r + 3'd1;
                                tx_reg_r <= b_reg_r[1];
                            end
                        end else begin
                            s_cnt_r <= s_cnt_r + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (s_tick_s) begin
                        if (s_cnt_r == BIT_LAST) begin
                            s_cnt_r  <= '0;
                            tx_reg_r <= 1'b1;
                            state_r  <= STOP;
                        end else begin
                            s_cnt_r <= s_cnt_r + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick_s) begin
                        if (s_cnt_r == STOP_LAST) begin
                            s_cnt_r <= '0;
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            s_cnt_r <= s_cnt_r + 1'b1;
                        end
                    end
                end
                default: begin
                    s_cnt_r  <= '0;
                    n_cnt_r  <= 3'd0;
                    tx_reg_r <= 1'b1;
                    busy_r   <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule
